// File: rtl/icache.sv
// Direct-mapped instruction cache: 8 lines of 16-byte blocks in front of a 128-bit
// read-only instruction memory. Hits return in the same cycle; misses stall the CPU.
module icache #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = 10,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_W-1:0]             ADDRESS,
  output logic [31:0]                   INSTRUCTION,
  output logic                          BUSYWAIT,
  output logic                          MEM_READ,
  output logic [TAG_W+INDEX_W-1:0]      MEM_ADDRESS,
  input  logic [8*(2**OFFSET_W)-1:0]    MEM_READINST,
  input  logic                          MEM_BUSYWAIT
);

  localparam int LINES   = 2 ** INDEX_W;
  localparam int BLOCK_W = 8 * (2 ** OFFSET_W);
  localparam int WORD_W  = OFFSET_W - 2;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_READ = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;

  logic [TAG_W-1:0]         addr_tag;
  logic [INDEX_W-1:0]       addr_idx;
  logic [WORD_W-1:0]        addr_word;
  logic                     addr_unused;

  logic [1:0]               state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_W+INDEX_W-1:0] miss_q, miss_d;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [BLOCK_W-1:0]       data_q [LINES];

  logic                     hit;
  logic                     fill_en;
  logic [INDEX_W-1:0]       miss_idx;
  logic [BLOCK_W-1:0]       line_data;

  assign addr_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx    = ADDRESS[OFFSET_W +: INDEX_W];
  assign addr_word   = ADDRESS[2 +: WORD_W];
  assign addr_unused = ^ADDRESS[1:0];
  assign miss_idx    = miss_q[INDEX_W-1:0];

  always_comb begin
    hit         = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    line_data   = data_q[addr_idx];
    INSTRUCTION = hit ? line_data[32*addr_word +: 32] : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d = S_MEM_READ;
          miss_d  = {addr_tag, addr_idx};
        end
      end
      S_MEM_READ: begin
        if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        valid_d[miss_idx] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must never be blocked by a stall, and aborts any fill in flight.
  assign fill_en     = (state_q == S_UPDATE) && !RESET;
  assign MEM_READ    = !RESET && (state_q == S_MEM_READ);
  assign BUSYWAIT    = !RESET && ((state_q != S_IDLE) || !hit);
  assign MEM_ADDRESS = miss_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_q[miss_idx] <= MEM_READINST;
      tag_q[miss_idx]  <= miss_q[INDEX_W +: TAG_W];
    end
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the CPU fetch port and the 128-bit-wide instruction memory. It replaces the zero-wait combinational fetch: on a hit it returns the 32-bit instruction with no stall, and on a miss it raises BUSYWAIT, fetches the whole 16-byte block from instruction memory and then serves the word. It shares CLK and RESET with cpu, dcache and data_memory.

## Interface
- INDEX_W, 3: index bits; 2^INDEX_W = 8 blocks.
- OFFSET_W, 4: byte-offset bits; 16-byte blocks, 4 words each.
- ADDR_W, 10: fetch address width, covering a 1024-byte instruction space.
- TAG_W, ADDR_W-INDEX_W-OFFSET_W = 3: tag width (derived).

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDRESS  in  10  CPU fetch address, PC[9:0]. Word-aligned; bits [1:0] are ignored.
- INSTRUCTION  out  32  fetched instruction.
- BUSYWAIT  out  1  stall request to the CPU; the CPU holds PC while this is 1.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address sent to memory: {tag, index}.
- MEM_READINST  in  128  block data from memory; word 0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; high while the read is in progress.

## Operation
- Address split: tag = ADDRESS[9:7], index = ADDRESS[6:4], word = ADDRESS[3:2].
- Storage per line: a valid bit, a 3-bit tag and 128 data bits.
- Hit = valid[index] && (tag_array[index] == tag), evaluated combinationally.
- INSTRUCTION = data[index][32*word +: 32] when hit, else 32'h0.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - MEM_READ = 0.
  - BUSYWAIT = !hit, combinational.
  - On a miss, the next edge latches {tag, index} into the miss register and the FSM moves to MEM_READ.
- MEM_READ:
  - MEM_READ = 1, MEM_ADDRESS = miss register, BUSYWAIT = 1.
  - The FSM stays here while MEM_BUSYWAIT = 1.
  - At the first edge sampling MEM_BUSYWAIT = 0 after the request, it moves to UPDATE.
- UPDATE:
  - MEM_READ = 0, BUSYWAIT = 1.
  - On the next edge: data[idx] ← MEM_READINST, tag[idx] ← miss tag, valid[idx] ← 1. The FSM returns to IDLE.
- No dirty state and no writeback; instruction memory is read-only.
- Block fill uses the latched miss address, never the live ADDRESS.
- RESET = 1 at an edge:
  - all valid bits clear and the FSM goes to IDLE;
  - the miss register resets to 0;
  - the tag and data arrays are not cleared.
  - RESET has priority over any in-progress miss, including in MEM_READ or UPDATE; no partial line is written.
- While RESET = 1, BUSYWAIT is forced to 0 so the CPU's PC reset is not blocked, and MEM_READ = 0.

## Timing
- Reset values: BUSYWAIT 0, MEM_READ 0, MEM_ADDRESS 6'h0, INSTRUCTION 32'h0 (all lines invalid).
- Hit: zero stall cycles. INSTRUCTION is valid in the same cycle ADDRESS is presented.
  - Simulation models #1 for tag compare and #1 for word select, replacing the #2 instruction-fetch delay.
- Miss latency: 1 cycle (IDLE→MEM_READ) + N memory busy cycles + 1 cycle (UPDATE) + the hit cycle.
  - BUSYWAIT drops combinationally in the IDLE cycle after UPDATE.
- MEM_READ must be high on the edge memory samples the request, and must remain high until MEM_BUSYWAIT falls.
- MEM_ADDRESS is stable for the whole of MEM_READ.
- ADDRESS changes while BUSYWAIT = 1 are a CPU protocol violation. The cache completes the fill of the latched block, then re-evaluates hit against the current ADDRESS.
- Sequential fetch crossing a block boundary (ADDRESS[3:2] 3→0 with index+1) is treated as an independent lookup.
- Index wrap 7→0 with tag+1 is treated as an independent lookup.
- Simultaneous RESET and MEM_BUSYWAIT falling: RESET wins; the line stays invalid.

## Test plan
- Reset: hold RESET 2 cycles, then release with ADDRESS = 0 → BUSYWAIT rises the same cycle (cold miss); MEM_READ = 1 and MEM_ADDRESS = 6'h00 on the next cycle.
- Cold miss fill: memory returns 128'h00000003_00000002_00000001_00000000 after 5 busy cycles, with ADDRESS = 10'h004 → INSTRUCTION = 32'h00000001 and BUSYWAIT = 0 exactly 7 cycles after the miss.
- Same-block hits: ADDRESS 10'h000, 10'h008, 10'h00C after the fill → INSTRUCTION 0, 2, 3. BUSYWAIT stays 0 and MEM_READ stays 0 throughout.
- Conflict miss: ADDRESS = 10'h080 (tag 1, index 0) → miss, MEM_ADDRESS = 6'h08, line 0 replaced. Returning to 10'h000 then misses again.
- Reset mid-fill: assert RESET during the MEM_READ state → next edge gives MEM_READ = 0, FSM in IDLE, line invalid; a later access to the same address misses.
- Block-boundary walk: PC from 10'h000 to 10'h03C in steps of 4 → exactly 4 misses, at 0x00, 0x10, 0x20 and 0x30. All other fetches are hits with correct words.
